// File: rtl/uart_rx_fifo.sv
// Receive-side character FIFO for the UART, with edge-detected push/error strobes.
// Latency: a push is visible in count one cycle later; pop data/valid are registered one cycle after rd_en.
// Backpressure: none toward the receiver; a push into a full FIFO without a same-cycle pop is dropped and flagged in overflow.
`ifndef NUM_DATA_BITS
`define NUM_DATA_BITS 8
`endif

module uart_rx_fifo #(
    parameter int DATA_BITS = `NUM_DATA_BITS,
    parameter int DEPTH     = 16
) (
    input  logic                   baud,
    input  logic                   rst,
    input  logic [DATA_BITS-1:0]   rx_data,
    input  logic                   rx_done,
    input  logic                   rx_error,
    input  logic                   flush,
    input  logic                   rd_en,
    output logic [DATA_BITS-1:0]   rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [7:0]             err_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 done_q;
    logic                 err_q;

    logic push_ev;
    logic err_ev;
    logic pop;
    logic wr_ok;
    logic drop;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A pop frees the slot the push lands in, so a full FIFO can still accept a push alongside a pop.
    always_comb begin
        push_ev = rx_done & ~done_q;
        err_ev  = rx_error & ~err_q;
        pop     = rd_en & ~empty;
        wr_ok   = push_ev & (~full | pop);
        drop    = push_ev & full & ~pop;
    end

    always_ff @(posedge baud) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            err_count <= 8'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= rx_done;
            err_q  <= rx_error;
            if (err_ev && err_count != 8'hFF) begin
                err_count <= err_count + 8'd1;
            end
            if (flush) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
                rd_valid <= 1'b0;
            end else begin
                rd_valid <= pop;
                if (pop) begin
                    rd_data <= mem[rd_ptr];
                    rd_ptr  <= rd_ptr + AW'(1);
                end
                if (wr_ok) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (drop) begin
                    overflow <= 1'b1;
                end
                case ({wr_ok, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: ;
                endcase
            end
        end
    end

    // Storage is left unreset; only pointers and count define what is valid.
    always_ff @(posedge baud) begin
        if (wr_ok && !flush && !rst) begin
            mem[wr_ptr] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed scenarios plus randomized traffic for uart_rx_fifo, scored against a queue-based model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       baud = 1'b0;
    logic       rst = 1'b1;
    logic       rx_done = 1'b0;
    logic       rx_error = 1'b0;
    logic       flush = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] err_count;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    logic [7:0] q[$];
    int         m_err = 0;
    bit         m_ovf = 0;
    bit         m_vld = 0;
    logic [7:0] m_rd = 8'h00;
    bit         m_pd = 0;
    bit         m_pe = 0;

    always #5 baud = ~baud;

    uart_rx_fifo #(.DATA_BITS(8), .DEPTH(DEPTH)) dut (
        .baud(baud), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
        .rx_error(rx_error), .flush(flush), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .empty(empty), .full(full), .count(count),
        .overflow(overflow), .err_count(err_count)
    );

    // Drive one cycle of inputs, advance the model across the edge, and settle 1 time unit past it.
    task automatic cycle(input bit r, input bit d, input logic [7:0] dat,
                         input bit e, input bit f, input bit rd);
        bit push;
        bit popped;
        rst = r; rx_done = d; rx_data = dat; rx_error = e; flush = f; rd_en = rd;
        @(posedge baud);
        if (r) begin
            q.delete(); m_err = 0; m_ovf = 0; m_vld = 0; m_rd = 8'h00; m_pd = 0; m_pe = 0;
        end else begin
            push = d && !m_pd;
            if (e && !m_pe && m_err < 255) m_err++;
            if (f) begin
                q.delete();
                m_vld = 0;
            end else begin
                popped = rd && (q.size() > 0);
                if (popped) m_rd = q.pop_front();
                m_vld = popped;
                if (push) begin
                    if (q.size() < DEPTH) q.push_back(dat);
                    else m_ovf = 1;
                end
            end
            m_pd = d;
            m_pe = e;
        end
        #1;
    endtask

    task automatic push_pulse(input logic [7:0] dat);
        cycle(0, 1, dat, 0, 0, 0);
        cycle(0, 0, dat, 0, 0, 0);
    endtask

    task automatic test_reset();
        cycle(1, 0, 8'h00, 0, 0, 0);
        cycle(1, 0, 8'h00, 0, 0, 0);
        n_vec++; if (count !== 5'd0) begin n_bad++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_vec++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b expected 1", empty); end
        n_vec++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b expected 0", full); end
        n_vec++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        n_vec++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
        n_vec++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        n_vec++; if (err_count !== 8'd0) begin n_bad++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
    endtask

    task automatic test_basic_pop();
        cycle(0, 0, 8'h00, 0, 0, 0);
        push_pulse(8'h41);
        push_pulse(8'h42);
        push_pulse(8'h43);
        n_vec++; if (count !== 5'd3) begin n_bad++; $display("FAIL basic_count3: got %0d expected 3", count); end
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp_d;
            cycle(0, 0, 8'h00, 0, 0, 1);
            exp_d = 8'h41 + 8'(i);
            n_vec++; if (rd_valid !== (i < 3)) begin n_bad++; $display("FAIL basic_rd_valid[%0d]: got %b expected %b", i, rd_valid, (i < 3)); end
            if (i < 3) begin
                n_vec++; if (rd_data !== exp_d) begin n_bad++; $display("FAIL basic_rd_data[%0d]: got %h expected %h", i, rd_data, exp_d); end
            end
        end
        n_vec++; if (empty !== 1'b1 || count !== 5'd0) begin n_bad++; $display("FAIL basic_drained: got empty=%b count=%0d expected empty=1 count=0", empty, count); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 17; i++) begin
            push_pulse(8'(i));
            if (i == 14) begin
                n_vec++; if (full !== 1'b0) begin n_bad++; $display("FAIL fill_full_at15: got %b expected 0", full); end
            end
            if (i == 15) begin
                n_vec++; if (full !== 1'b1) begin n_bad++; $display("FAIL fill_full_at16: got %b expected 1", full); end
                n_vec++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fill_overflow_at16: got %b expected 0", overflow); end
            end
        end
        n_vec++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL fill_overflow_at17: got %b expected 1", overflow); end
        n_vec++; if (count !== 5'd16) begin n_bad++; $display("FAIL fill_count: got %0d expected 16", count); end
        for (int i = 0; i < 16; i++) begin
            cycle(0, 0, 8'h00, 0, 0, 1);
            n_vec++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin n_bad++; $display("FAIL fill_pop[%0d]: got vld=%b data=%h expected vld=1 data=%h", i, rd_valid, rd_data, 8'(i)); end
        end
        cycle(0, 0, 8'h00, 0, 0, 0);
        n_vec++; if (empty !== 1'b1) begin n_bad++; $display("FAIL fill_empty: got %b expected 1", empty); end
    endtask

    task automatic test_full_push_pop();
        cycle(1, 0, 8'h00, 0, 0, 0);
        cycle(0, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 16; i++) push_pulse(8'h10 + 8'(i));
        n_vec++; if (full !== 1'b1) begin n_bad++; $display("FAIL fpp_full: got %b expected 1", full); end
        cycle(0, 1, 8'hAA, 0, 0, 1);
        n_vec++; if (rd_valid !== 1'b1 || rd_data !== 8'h10) begin n_bad++; $display("FAIL fpp_oldest: got vld=%b data=%h expected vld=1 data=10", rd_valid, rd_data); end
        n_vec++; if (count !== 5'd16) begin n_bad++; $display("FAIL fpp_count: got %0d expected 16", count); end
        n_vec++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_overflow: got %b expected 0", overflow); end
        for (int j = 1; j <= 16; j++) begin
            logic [7:0] exp_d;
            cycle(0, 0, 8'h00, 0, 0, 1);
            exp_d = (j < 16) ? 8'h10 + 8'(j) : 8'hAA;
            n_vec++; if (rd_data !== exp_d) begin n_bad++; $display("FAIL fpp_pop[%0d]: got %h expected %h", j, rd_data, exp_d); end
        end
        n_vec++; if (empty !== 1'b1) begin n_bad++; $display("FAIL fpp_empty: got %b expected 1", empty); end
    endtask

    task automatic test_level_and_errors();
        cycle(1, 0, 8'h00, 0, 0, 0);
        repeat (5) cycle(0, 1, 8'h55, 0, 0, 0);
        cycle(0, 0, 8'h00, 0, 0, 0);
        n_vec++; if (count !== 5'd1) begin n_bad++; $display("FAIL level_push_once: got %0d expected 1", count); end
        for (int i = 0; i < 300; i++) begin
            cycle(0, 0, 8'h00, 1, 0, 0);
            cycle(0, 0, 8'h00, 0, 0, 0);
            if (i == 253) begin
                n_vec++; if (err_count !== 8'd254) begin n_bad++; $display("FAIL err_254: got %0d expected 254", err_count); end
            end
        end
        n_vec++; if (err_count !== 8'd255) begin n_bad++; $display("FAIL err_saturate: got %0d expected 255", err_count); end
        n_vec++; if (count !== 5'd1) begin n_bad++; $display("FAIL err_no_push: got %0d expected 1", count); end
        cycle(0, 0, 8'h00, 0, 0, 1);
        n_vec++; if (rd_data !== 8'h55) begin n_bad++; $display("FAIL level_data: got %h expected 55", rd_data); end
    endtask

    task automatic test_flush_then_reset();
        for (int i = 0; i < 17; i++) push_pulse(8'(i));
        for (int i = 0; i < 11; i++) cycle(0, 0, 8'h00, 0, 0, 1);
        cycle(0, 0, 8'h00, 0, 0, 0);
        n_vec++; if (count !== 5'd5) begin n_bad++; $display("FAIL flush_pre_count: got %0d expected 5", count); end
        cycle(0, 1, 8'h77, 0, 1, 1);
        n_vec++; if (count !== 5'd0 || empty !== 1'b1) begin n_bad++; $display("FAIL flush_clear: got count=%0d empty=%b expected count=0 empty=1", count, empty); end
        n_vec++; if (rd_valid !== 1'b0) begin n_bad++; $display("FAIL flush_rd_valid: got %b expected 0", rd_valid); end
        n_vec++; if (overflow !== 1'b1 || err_count !== 8'd255) begin n_bad++; $display("FAIL flush_keep: got ovf=%b err=%0d expected ovf=1 err=255", overflow, err_count); end
        cycle(0, 0, 8'h00, 0, 0, 1);
        n_vec++; if (rd_valid !== 1'b0 || rd_data !== 8'h0A) begin n_bad++; $display("FAIL empty_rd_ignored: got vld=%b data=%h expected vld=0 data=0a", rd_valid, rd_data); end
        cycle(1, 1, 8'h99, 0, 0, 0);
        n_vec++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL rst_flags: got count=%0d empty=%b full=%b expected 0/1/0", count, empty, full); end
        n_vec++; if (overflow !== 1'b0 || err_count !== 8'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin n_bad++; $display("FAIL rst_outputs: got ovf=%b err=%0d vld=%b data=%h expected all 0", overflow, err_count, rd_valid, rd_data); end
        cycle(0, 1, 8'h99, 0, 0, 0);
        n_vec++; if (count !== 5'd1) begin n_bad++; $display("FAIL rst_release_push: got %0d expected 1", count); end
        cycle(0, 1, 8'h99, 0, 0, 0);
        n_vec++; if (count !== 5'd1) begin n_bad++; $display("FAIL rst_release_once: got %0d expected 1", count); end
        cycle(0, 0, 8'h00, 0, 0, 1);
        n_vec++; if (rd_data !== 8'h99) begin n_bad++; $display("FAIL rst_release_data: got %h expected 99", rd_data); end
    endtask

    task automatic test_wrap();
        int         level = 0;
        logic [7:0] next_in = 8'h00;
        logic [7:0] next_out = 8'h00;
        cycle(1, 0, 8'h00, 0, 0, 0);
        cycle(0, 0, 8'h00, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            if (level == 0 || (level < DEPTH && $urandom_range(0, 2) != 0)) begin
                push_pulse(next_in);
                next_in++;
                level++;
            end else begin
                cycle(0, 0, 8'h00, 0, 0, 1);
                n_vec++; if (rd_valid !== 1'b1 || rd_data !== next_out) begin n_bad++; $display("FAIL wrap_order[%0d]: got vld=%b data=%h expected vld=1 data=%h", i, rd_valid, rd_data, next_out); end
                next_out++;
                level--;
            end
            n_vec++; if (count > 5'd16 || count !== 5'(level)) begin n_bad++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", i, count, level); end
        end
        n_vec++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL wrap_overflow: got %b expected 0", overflow); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0, 8'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 4) < 2);
            n_vec++;
            if (count !== 5'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == DEPTH) ||
                rd_valid !== m_vld || rd_data !== m_rd || overflow !== m_ovf || err_count !== 8'(m_err)) begin
                n_bad++;
                $display("FAIL random[%0d]: got cnt=%0d emp=%b ful=%b vld=%b dat=%h ovf=%b err=%0d expected cnt=%0d vld=%b dat=%h ovf=%b err=%0d",
                         i, count, empty, full, rd_valid, rd_data, overflow, err_count,
                         q.size(), m_vld, m_rd, m_ovf, m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_pop();
        test_fill_overflow();
        test_full_push_pop();
        test_level_and_errors();
        test_flush_then_reset();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
